iob_eth_rx_fcs_check: RTL and testbench

//  Receive-side Ethernet FCS checker. Consumes the byte stream from the RX MAC
//  (after preamble/SFD removal), runs CRC-32 over every byte including the

---
 rtl/iob_eth_pkg.sv | 30 +++
 rtl/iob_eth_fcs_dly.sv | 58 +++++
 rtl/iob_eth_rx_fcs_check.sv | 118 +++++++++++
 tb/tb_iob_eth_rx_fcs_check.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/iob_eth_pkg.sv
// Shared constants, FSM state type and byte-wide CRC-32 update for the
// Ethernet receive FCS path.
package iob_eth_pkg;

  localparam logic [31:0] CRC_INIT            = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE_DEFAULT = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY            = 32'h04C1_1DB7;
  localparam int unsigned FCS_BYTES           = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PASS,
    DONE
  } state_t;

  // Bits enter LSB first (wire order); the register is kept MSB-first, so a
  // good frame leaves the residue in its non-reflected form.
  function automatic logic [31:0] crc32_byte(input logic [7:0] data, input logic [31:0] crc);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/iob_eth_fcs_dly.sv
// Four-byte delay line that holds back the trailing FCS: a byte is released
// only once four newer bytes have arrived behind it.
module iob_eth_fcs_dly
  import iob_eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_en,
  input  logic [7:0] in_data,
  output logic [7:0] out_data,
  output logic       out_en
);

  logic [2:0] fill_reg;
  logic [7:0] out_data_reg;
  logic       out_en_reg;
  logic       full;

  genvar gi;
  generate
    for (gi = 0; gi < FCS_BYTES; gi++) begin : g_stage
      logic [7:0] q_reg;
      logic [7:0] d;
      if (gi == 0) begin : g_head
        assign d = in_data;
      end else begin : g_tail
        assign d = g_stage[gi-1].q_reg;
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        q_reg <= '0;
        else if (clr)   q_reg <= '0;
        else if (in_en) q_reg <= d;
      end
    end
  endgenerate

  assign full = (fill_reg == 3'(FCS_BYTES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_reg     <= '0;
      out_data_reg <= '0;
      out_en_reg   <= 1'b0;
    end else if (clr) begin
      fill_reg   <= '0;
      out_en_reg <= 1'b0;
    end else begin
      out_en_reg <= in_en && full;
      if (in_en && full)  out_data_reg <= g_stage[FCS_BYTES-1].q_reg;
      if (in_en && !full) fill_reg     <= fill_reg + 3'd1;
    end
  end

  assign out_data = out_data_reg;
  assign out_en   = out_en_reg;

endmodule

// File: rtl/iob_eth_rx_fcs_check.sv
// Receive FCS checker: CRC over the whole frame, FCS stripped from the byte
// stream, per-frame status pulsed on frame_done.
module iob_eth_rx_fcs_check
  import iob_eth_pkg::*;
#(
  parameter int unsigned MIN_LEN     = 64,
  parameter int unsigned MAX_LEN     = 1518,
  parameter logic [31:0] CRC_RESIDUE = CRC_RESIDUE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_start,
  input  logic [7:0]  rx_data,
  input  logic        rx_en,
  input  logic        rx_end,
  output logic [7:0]  out_data,
  output logic        out_en,
  output logic        frame_done,
  output logic        frame_crc_ok,
  output logic [15:0] frame_len,
  output logic        frame_err_short,
  output logic        frame_err_long
);

  state_t      state_reg, state_next;
  logic [31:0] crc_reg, crc_next;
  logic [16:0] cnt_reg, cnt_next;
  logic [16:0] len_diff;
  logic [15:0] len_next;
  logic        accept_byte, accept_end, clr;
  logic        crc_ok_reg, short_reg, long_reg;
  logic [15:0] len_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      crc_reg   <= CRC_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      crc_reg   <= crc_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    crc_next    = crc_reg;
    cnt_next    = cnt_reg;
    accept_byte = 1'b0;
    accept_end  = 1'b0;
    clr         = 1'b0;
    // A new start always wins and silently abandons any frame in flight.
    if (rx_start) begin
      clr        = 1'b1;
      crc_next   = CRC_INIT;
      cnt_next   = '0;
      state_next = FILL;
    end else begin
      case (state_reg)
        FILL, PASS: begin
          accept_byte = rx_en;
          accept_end  = rx_end;
          if (rx_en) begin
            crc_next = crc32_byte(rx_data, crc_reg);
            cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + 17'd1;
          end
          if (rx_end)
            state_next = DONE;
          else if (state_reg == FILL && cnt_next >= 17'(FCS_BYTES))
            state_next = PASS;
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    len_diff = cnt_next - 17'(FCS_BYTES);
    len_next = '0;
    if (cnt_next >= 17'(FCS_BYTES))
      len_next = len_diff[16] ? 16'hFFFF : len_diff[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_ok_reg <= 1'b0;
      len_reg    <= '0;
      short_reg  <= 1'b0;
      long_reg   <= 1'b0;
    end else if (accept_end) begin
      crc_ok_reg <= (cnt_next >= 17'(FCS_BYTES)) && (crc_next == CRC_RESIDUE);
      len_reg    <= len_next;
      short_reg  <= cnt_next < 17'(MIN_LEN);
      long_reg   <= cnt_next > 17'(MAX_LEN);
    end
  end

  // The last payload byte can emerge alongside frame_done when rx_end
  // coincides with the final FCS byte.
  iob_eth_fcs_dly u_dly (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_en    (accept_byte),
    .in_data  (rx_data),
    .out_data (out_data),
    .out_en   (out_en)
  );

  assign frame_done      = (state_reg == DONE);
  assign frame_crc_ok    = crc_ok_reg;
  assign frame_len       = len_reg;
  assign frame_err_short = short_reg;
  assign frame_err_long  = long_reg;

endmodule

// File: tb/tb_iob_eth_rx_fcs_check.sv
// Directed bench for the receive FCS checker: good/bad/short/long frames,
// aborted frames, back-to-back frames, rx_en gaps and mid-frame reset.
module tb_iob_eth_rx_fcs_check;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_en = 1'b0;
  logic        rx_end = 1'b0;
  logic [7:0]  out_data;
  logic        out_en;
  logic        frame_done;
  logic        frame_crc_ok;
  logic [15:0] frame_len;
  logic        frame_err_short;
  logic        frame_err_long;

  int tests_run = 0;
  int failures  = 0;
  int done_cnt  = 0;
  logic [7:0] frame_q[$];
  logic [7:0] out_q[$];

  iob_eth_rx_fcs_check dut (
    .clk             (clk),
    .rst             (rst),
    .rx_start        (rx_start),
    .rx_data         (rx_data),
    .rx_en           (rx_en),
    .rx_end          (rx_end),
    .out_data        (out_data),
    .out_en          (out_en),
    .frame_done      (frame_done),
    .frame_crc_ok    (frame_crc_ok),
    .frame_len       (frame_len),
    .frame_err_short (frame_err_short),
    .frame_err_long  (frame_err_long)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_en) out_q.push_back(out_data);
    if (frame_done) done_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Payload of incrementing bytes followed by a standard Ethernet FCS
  // computed with the shift-right reflected algorithm.
  task automatic build_good(input int total);
    logic [31:0] c;
    frame_q.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < total - 4; i++) begin
      frame_q.push_back(8'(i));
      c = c ^ {24'h0, 8'(i)};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    frame_q.push_back(c[7:0]);
    frame_q.push_back(c[15:8]);
    frame_q.push_back(c[23:16]);
    frame_q.push_back(c[31:24]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    rx_en = 1'b1; rx_data = b; rx_end = last;
    @(posedge clk); #1;
    rx_en = 1'b0; rx_end = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit with_end, input bit gaps);
    rx_start = 1'b1;
    @(posedge clk); #1;
    rx_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(1)) begin @(posedge clk); #1; end
      send_byte(frame_q[i], with_end && (i == n - 1));
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic int payload_errs(input int n);
    int e = 0;
    for (int i = 0; i < n; i++)
      if (out_q[i] !== frame_q[i]) e++;
    return e;
  endfunction

  task automatic check_status(input string tag, input int d0, input int n_out,
                              input logic ok, input int len, input logic sh, input logic lg);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_out_cnt"}, out_q.size(), n_out);
    check({tag, "_crc_ok"}, frame_crc_ok, ok);
    check({tag, "_len"}, frame_len, len);
    check({tag, "_short"}, frame_err_short, sh);
    check({tag, "_long"}, frame_err_long, lg);
    $display("[TB] %s: out=%0d ok=%0b len=%0d short=%0b long=%0b", tag, out_q.size(),
             frame_crc_ok, frame_len, frame_err_short, frame_err_long);
  endtask

  initial begin
    int d0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_en", out_en, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", frame_done, 0);
    check("rst_status", {frame_crc_ok, frame_err_short, frame_err_long, frame_len}, 0);
    $display("[TB] reset state checked");
    rst = 1'b0;
    @(posedge clk); #1;

    // Good minimum-size frame
    build_good(64); out_q.delete(); d0 = done_cnt;
    send_frame(64, 1, 0); settle();
    check_status("good64", d0, 60, 1, 60, 0, 0);
    check("good64_payload", payload_errs(60), 0);

    // Single-bit corruption in the payload
    build_good(64); frame_q[10] = frame_q[10] ^ 8'h01;
    out_q.delete(); d0 = done_cnt;
    send_frame(64, 1, 0); settle();
    check_status("bad64", d0, 60, 0, 60, 0, 0);
    check("bad64_payload", payload_errs(60), 0);

    // Runt shorter than the FCS itself
    frame_q = '{8'h11, 8'h22, 8'h33}; out_q.delete(); d0 = done_cnt;
    send_frame(3, 1, 0); settle();
    check_status("runt3", d0, 0, 0, 0, 1, 0);

    // Oversize good frame
    build_good(1519); out_q.delete(); d0 = done_cnt;
    send_frame(1519, 1, 0); settle();
    check_status("long1519", d0, 1515, 1, 1515, 0, 1);
    check("long1519_payload", payload_errs(1515), 0);

    // Frame A aborted by a new rx_start after 20 bytes, then good frame B
    build_good(64); out_q.delete(); d0 = done_cnt;
    send_frame(20, 0, 0);
    send_frame(64, 1, 0); settle();
    check_status("abort", d0, 76, 1, 60, 0, 0);

    // Back-to-back frames: rx_start in the frame_done cycle
    build_good(64); out_q.delete(); d0 = done_cnt;
    send_frame(64, 1, 0);
    send_frame(64, 1, 0); settle();
    check("b2b_done", done_cnt - d0, 2);
    check("b2b_out_cnt", out_q.size(), 120);
    check("b2b_crc_ok", frame_crc_ok, 1);
    $display("[TB] b2b: done=%0d out=%0d ok=%0b", done_cnt - d0, out_q.size(), frame_crc_ok);

    // Random rx_en gaps, last byte coincident with rx_end
    build_good(64); out_q.delete(); d0 = done_cnt;
    send_frame(64, 1, 1); settle();
    check_status("gaps", d0, 60, 1, 60, 0, 0);
    check("gaps_payload", payload_errs(60), 0);

    // Asynchronous reset while passing bytes through
    build_good(64); out_q.delete(); d0 = done_cnt;
    send_frame(30, 0, 0);
    check("pre_rst_out_en", out_en, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_en", out_en, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_status", {frame_crc_ok, frame_err_short, frame_err_long, frame_len}, 0);
    $display("[TB] mid-frame reset applied");
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    build_good(65); out_q.delete(); d0 = done_cnt;
    send_frame(65, 1, 0); settle();
    check_status("post_rst", d0, 61, 1, 61, 0, 0);
    check("post_rst_payload", payload_errs(61), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
